fetch_redirect_unit: RTL and testbench

Fetch-side consumer of the control hazard unit's `select_pc`/`flush`/`stall` triple.
- Owns the program counter and the IF/ID pipeline register.
- Applies taken-branch redirects and inserts bubbles into IF/ID and ID/EX.
- Honours load-use holds from the data hazard unit.
- Counts taken branches for performance monitoring.

---
 rtl/fetch_redirect_unit.sv | 93 +++++++++
 tb/tb_fetch_redirect_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_redirect_unit.sv
// rtl/fetch_redirect_unit.sv - PC owner and IF/ID register driven by hazard-unit redirect/flush/stall
module fetch_redirect_unit #(
    parameter int          IMEM_LAT = 0,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        select_pc,
    input  logic        flush,
    input  logic        stall,
    input  logic [31:0] branch_target,
    input  logic        hold,
    input  logic [31:0] instr_mem_data,
    output logic [31:0] pc,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic        ifid_valid,
    output logic        idex_kill,
    output logic        redirect_busy,
    output logic [15:0] taken_count
);

    localparam int KW = (IMEM_LAT > 0) ? $clog2(IMEM_LAT + 1) : 1;

    localparam logic [0:0]    S_RUN       = 1'b0;
    localparam logic [0:0]    S_KILL      = 1'b1;
    localparam logic [KW-1:0] KILL_INIT   = KW'(IMEM_LAT);
    localparam logic [0:0]    RESET_STATE = (IMEM_LAT != 0) ? S_KILL : S_RUN;
    localparam logic [KW-1:0] RESET_CNT   = (IMEM_LAT != 0) ? KILL_INIT : '0;

    logic [0:0]    state;
    logic [KW-1:0] kill_cnt;
    logic [31:0]   pc_q;
    logic [31:0]   pc_next_seq;
    logic [31:0]   fetch_pc;
    logic          freeze;

    assign freeze        = hold | stall;
    assign idex_kill     = select_pc | flush | freeze;
    assign redirect_busy = (state == S_KILL);
    assign pc_next_seq   = pc + PC_STEP;
    // With a registered memory the data on the bus belongs to last cycle's fetch address.
    assign fetch_pc      = (IMEM_LAT == 0) ? pc : pc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= RESET_PC;
            pc_q        <= RESET_PC;
            ifid_instr  <= '0;
            ifid_pc     <= '0;
            ifid_valid  <= 1'b0;
            taken_count <= '0;
            state       <= RESET_STATE;
            kill_cnt    <= RESET_CNT;
        end else if (select_pc) begin
            pc         <= branch_target;
            pc_q       <= pc;
            ifid_instr <= '0;
            ifid_valid <= 1'b0;
            if (taken_count != 16'hFFFF) begin
                taken_count <= taken_count + 16'd1;
            end
            if (IMEM_LAT != 0) begin
                state    <= S_KILL;
                kill_cnt <= KILL_INIT;
            end
        end else if (flush) begin
            pc         <= pc_next_seq;
            pc_q       <= pc;
            ifid_instr <= '0;
            ifid_valid <= 1'b0;
        end else if (freeze) begin
            // Everything holds; only idex_kill reacts.
        end else if (state == S_KILL) begin
            pc         <= pc_next_seq;
            pc_q       <= pc;
            ifid_instr <= '0;
            ifid_valid <= 1'b0;
            kill_cnt   <= kill_cnt - KW'(1);
            if (kill_cnt <= KW'(1)) begin
                state <= S_RUN;
            end
        end else begin
            pc         <= pc_next_seq;
            pc_q       <= pc;
            ifid_instr <= instr_mem_data;
            ifid_valid <= 1'b1;
            ifid_pc    <= fetch_pc;
        end
    end

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// tb/tb_fetch_redirect_unit.sv - table-driven bench for fetch_redirect_unit at IMEM_LAT 0 and 1
module tb_fetch_redirect_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0, fl = 1'b0, st = 1'b0, hd = 1'b0;
    logic [31:0] tgt = '0;

    logic [31:0] pc0, instr0, ipc0, mem0;
    logic        v0, kill0, busy0;
    logic [15:0] cnt0;
    logic [31:0] pc1, instr1, ipc1, mem1;
    logic        v1, kill1, busy1;
    logic [15:0] cnt1;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    assign mem0 = pc0 + 32'h100;

    // Registered memory: read port gated off while fetch is frozen.
    always_ff @(posedge clk) begin
        if (sel | fl | ~(hd | st)) mem1 <= pc1 + 32'h100;
    end

    fetch_redirect_unit #(.IMEM_LAT(0), .RESET_PC(32'h0), .PC_STEP(32'd4)) dut0 (
        .clk(clk), .rst(rst_n), .select_pc(sel), .flush(fl), .stall(st),
        .branch_target(tgt), .hold(hd), .instr_mem_data(mem0), .pc(pc0),
        .ifid_instr(instr0), .ifid_pc(ipc0), .ifid_valid(v0), .idex_kill(kill0),
        .redirect_busy(busy0), .taken_count(cnt0)
    );

    fetch_redirect_unit #(.IMEM_LAT(1), .RESET_PC(32'h0), .PC_STEP(32'd4)) dut1 (
        .clk(clk), .rst(rst_n), .select_pc(sel), .flush(fl), .stall(st),
        .branch_target(tgt), .hold(hd), .instr_mem_data(mem1), .pc(pc1),
        .ifid_instr(instr1), .ifid_pc(ipc1), .ifid_valid(v1), .idex_kill(kill1),
        .redirect_busy(busy1), .taken_count(cnt1)
    );

    typedef struct {
        logic [3:0]  ctl;
        logic        kill;
        logic [31:0] tgt;
        logic [15:0] cnt;
        logic [31:0] pc0;
        logic        v0;
        logic [31:0] ipc0;
        logic [31:0] ins0;
        logic        busy1;
        logic [31:0] pc1;
        logic        v1;
        logic [31:0] ipc1;
        logic [31:0] ins1;
    } vec_t;

    vec_t vecs[$];

    localparam logic [3:0] IDLE = 4'b0000;
    localparam logic [3:0] BR   = 4'b1110;
    localparam logic [3:0] HD   = 4'b0001;
    localparam logic [3:0] HB   = 4'b1111;
    localparam logic [3:0] FL   = 4'b0100;
    localparam logic [3:0] ST   = 4'b0010;

    task automatic add(input logic [3:0] ctl, input logic kill, input logic [31:0] t,
                       input logic [15:0] cnt, input logic [31:0] p0, input logic vv0,
                       input logic [31:0] ip0, input logic [31:0] in0, input logic b1,
                       input logic [31:0] p1, input logic vv1, input logic [31:0] ip1,
                       input logic [31:0] in1);
        vec_t v;
        v.ctl = ctl; v.kill = kill; v.tgt = t; v.cnt = cnt;
        v.pc0 = p0; v.v0 = vv0; v.ipc0 = ip0; v.ins0 = in0;
        v.busy1 = b1; v.pc1 = p1; v.v1 = vv1; v.ipc1 = ip1; v.ins1 = in1;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int step, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
    endtask

    task automatic drive(input logic [3:0] ctl, input logic [31:0] t);
        {sel, fl, st, hd} = ctl;
        tgt = t;
    endtask

    initial begin
        //   ctl  kill tgt        cnt  pc0         v0 ipc0        ins0       busy1 pc1        v1 ipc1        ins1
        add(IDLE, 0, 32'h0,       0, 32'h4,        1, 32'h0,       32'h100,   0, 32'h4,        0, 32'h0,       32'h0);
        add(IDLE, 0, 32'h0,       0, 32'h8,        1, 32'h4,       32'h104,   0, 32'h8,        1, 32'h0,       32'h100);
        add(IDLE, 0, 32'h0,       0, 32'hC,        1, 32'h8,       32'h108,   0, 32'hC,        1, 32'h4,       32'h104);
        add(IDLE, 0, 32'h0,       0, 32'h10,       1, 32'hC,       32'h10C,   0, 32'h10,       1, 32'h8,       32'h108);
        add(BR,   1, 32'h40,      1, 32'h40,       0, 32'hC,       32'h0,     1, 32'h40,       0, 32'h8,       32'h0);
        add(IDLE, 0, 32'h0,       1, 32'h44,       1, 32'h40,      32'h140,   0, 32'h44,       0, 32'h8,       32'h0);
        add(HD,   1, 32'h0,       1, 32'h44,       1, 32'h40,      32'h140,   0, 32'h44,       0, 32'h8,       32'h0);
        add(HB,   1, 32'h80,      2, 32'h80,       0, 32'h40,      32'h0,     1, 32'h80,       0, 32'h8,       32'h0);
        add(HD,   1, 32'h0,       2, 32'h80,       0, 32'h40,      32'h0,     1, 32'h80,       0, 32'h8,       32'h0);
        add(IDLE, 0, 32'h0,       2, 32'h84,       1, 32'h80,      32'h180,   0, 32'h84,       0, 32'h8,       32'h0);
        add(FL,   1, 32'h0,       2, 32'h88,       0, 32'h80,      32'h0,     0, 32'h88,       0, 32'h8,       32'h0);
        add(ST,   1, 32'h0,       2, 32'h88,       0, 32'h80,      32'h0,     0, 32'h88,       0, 32'h8,       32'h0);
        add(IDLE, 0, 32'h0,       2, 32'h8C,       1, 32'h88,      32'h188,   0, 32'h8C,       1, 32'h84,      32'h184);
        add(BR,   1, 32'hFFFFFFFC, 3, 32'hFFFFFFFC, 0, 32'h88,      32'h0,     1, 32'hFFFFFFFC, 0, 32'h84,      32'h0);
        add(IDLE, 0, 32'h0,       3, 32'h0,        1, 32'hFFFFFFFC, 32'hFC,   0, 32'h0,        0, 32'h84,      32'h0);
        add(IDLE, 0, 32'h0,       3, 32'h4,        1, 32'h0,       32'h100,   0, 32'h4,        1, 32'hFFFFFFFC, 32'hFC);
        add(IDLE, 0, 32'h0,       3, 32'h8,        1, 32'h4,       32'h104,   0, 32'h8,        1, 32'h0,       32'h100);
        add(BR,   1, 32'h80,      4, 32'h80,       0, 32'h4,       32'h0,     1, 32'h80,       0, 32'h0,       32'h0);
        add(BR,   1, 32'hC0,      5, 32'hC0,       0, 32'h4,       32'h0,     1, 32'hC0,       0, 32'h0,       32'h0);
        add(IDLE, 0, 32'h0,       5, 32'hC4,       1, 32'hC0,      32'h1C0,   0, 32'hC4,       0, 32'h0,       32'h0);
        add(IDLE, 0, 32'h0,       5, 32'hC8,       1, 32'hC4,      32'h1C4,   0, 32'hC8,       1, 32'hC0,      32'h1C0);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_pc0", -1, pc0, 32'h0);
        chk("rst_pc1", -1, pc1, 32'h0);
        chk("rst_valid0", -1, {31'b0, v0}, 32'h0);
        chk("rst_ifid_pc0", -1, ipc0, 32'h0);
        chk("rst_instr1", -1, instr1, 32'h0);
        chk("rst_busy0", -1, {31'b0, busy0}, 32'h0);
        chk("rst_busy1", -1, {31'b0, busy1}, 32'h1);
        chk("rst_cnt0", -1, {16'b0, cnt0}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            if (i != 0) @(negedge clk);
            drive(vecs[i].ctl, vecs[i].tgt);
            #1;
            chk("idex_kill0", i, {31'b0, kill0}, {31'b0, vecs[i].kill});
            chk("idex_kill1", i, {31'b0, kill1}, {31'b0, vecs[i].kill});
            @(posedge clk);
            #1;
            chk("pc0", i, pc0, vecs[i].pc0);
            chk("ifid_valid0", i, {31'b0, v0}, {31'b0, vecs[i].v0});
            chk("ifid_pc0", i, ipc0, vecs[i].ipc0);
            chk("ifid_instr0", i, instr0, vecs[i].ins0);
            chk("busy0", i, {31'b0, busy0}, 32'h0);
            chk("count0", i, {16'b0, cnt0}, {16'b0, vecs[i].cnt});
            chk("pc1", i, pc1, vecs[i].pc1);
            chk("ifid_valid1", i, {31'b0, v1}, {31'b0, vecs[i].v1});
            chk("ifid_pc1", i, ipc1, vecs[i].ipc1);
            chk("ifid_instr1", i, instr1, vecs[i].ins1);
            chk("busy1", i, {31'b0, busy1}, {31'b0, vecs[i].busy1});
            chk("count1", i, {16'b0, cnt1}, {16'b0, vecs[i].cnt});
        end

        // Asynchronous reset in the middle of a redirect/KILL sequence.
        @(negedge clk);
        drive(BR, 32'h200);
        @(posedge clk);
        #1;
        chk("pre_rst_busy1", 0, {31'b0, busy1}, 32'h1);
        drive(IDLE, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pc0", 0, pc0, 32'h0);
        chk("async_rst_pc1", 0, pc1, 32'h0);
        chk("async_rst_cnt1", 0, {16'b0, cnt1}, 32'h0);
        chk("async_rst_ifid_pc1", 0, ipc1, 32'h0);
        chk("async_rst_valid0", 0, {31'b0, v0}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Saturation of the taken-branch counter.
        drive(BR, 32'h100);
        repeat (65534) @(posedge clk);
        #1;
        chk("count_fffe", 0, {16'b0, cnt0}, 32'hFFFE);
        @(posedge clk);
        #1;
        chk("count_ffff0", 0, {16'b0, cnt0}, 32'hFFFF);
        chk("count_ffff1", 0, {16'b0, cnt1}, 32'hFFFF);
        repeat (3) @(posedge clk);
        #1;
        chk("count_sat0", 0, {16'b0, cnt0}, 32'hFFFF);
        chk("count_sat1", 0, {16'b0, cnt1}, 32'hFFFF);
        chk("sat_pc0", 0, pc0, 32'h100);
        @(negedge clk);
        drive(IDLE, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
